// File: rtl/seven_segment_decoder.sv
// Registered hex-to-seven-segment decoder with blanking and selectable polarity.
// Optional lamp test input is enabled by defining LAMP_TEST_EN.
module seven_segment_decoder #(
   parameter logic ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] binary_in,
   input  logic       blank,
`ifdef LAMP_TEST_EN
   input  logic       lamp_test,
`endif
   output logic [6:0] segment_out
);

   localparam logic [6:0] SEG_DARK = 7'b0000000;
   localparam logic [6:0] SEG_LIT  = 7'b1111111;

   // XOR mask folds the common-anode inversion into every registered value
   localparam logic [6:0] POL_MASK = {7{ACTIVE_LOW}};

   logic [6:0] decoded;
   logic [6:0] seg_next;

   always_comb begin
      decoded = SEG_DARK;
      case (binary_in)
         4'h0: decoded = 7'b1111110;
         4'h1: decoded = 7'b0110000;
         4'h2: decoded = 7'b1101101;
         4'h3: decoded = 7'b1111001;
         4'h4: decoded = 7'b0110011;
         4'h5: decoded = 7'b1011011;
         4'h6: decoded = 7'b1011111;
         4'h7: decoded = 7'b1110000;
         4'h8: decoded = 7'b1111111;
         4'h9: decoded = 7'b1111011;
         4'hA: decoded = 7'b1110111;
         4'hB: decoded = 7'b0011111;
         4'hC: decoded = 7'b1001110;
         4'hD: decoded = 7'b0111101;
         4'hE: decoded = 7'b1001111;
         4'hF: decoded = 7'b1000111;
      endcase
   end

   always_comb begin
      seg_next = decoded;
`ifdef LAMP_TEST_EN
      if (lamp_test)
         seg_next = SEG_LIT;
      else if (blank)
         seg_next = SEG_DARK;
`else
      if (blank)
         seg_next = SEG_DARK;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst)
         segment_out <= SEG_DARK ^ POL_MASK;
      else
         segment_out <= seg_next ^ POL_MASK;
   end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed self-checking bench for seven_segment_decoder; runs both polarities side by side.
// Lamp test scenario is exercised when LAMP_TEST_EN is defined.
module tb_seven_segment_decoder;

   logic       clk;
   logic       rst;
   logic [3:0] binary_in;
   logic       blank;
   logic       lamp_test;
   logic [6:0] seg_hi;
   logic [6:0] seg_lo;

   int checks;
   int errors;

   logic [6:0] table_exp [16];

   seven_segment_decoder #(.ACTIVE_LOW(1'b0)) dut_cc (
      .clk         (clk),
      .rst         (rst),
      .binary_in   (binary_in),
      .blank       (blank),
`ifdef LAMP_TEST_EN
      .lamp_test   (lamp_test),
`endif
      .segment_out (seg_hi)
   );

   seven_segment_decoder #(.ACTIVE_LOW(1'b1)) dut_ca (
      .clk         (clk),
      .rst         (rst),
      .binary_in   (binary_in),
      .blank       (blank),
`ifdef LAMP_TEST_EN
      .lamp_test   (lamp_test),
`endif
      .segment_out (seg_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; blank = 1'b0; lamp_test = 1'b0; binary_in = 4'h8;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (seg_hi !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_cc cycle %0d: got %b expected %b", i, seg_hi, 7'b0000000);
         end
         checks++;
         if (seg_lo !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_ca cycle %0d: got %b expected %b", i, seg_lo, 7'b1111111);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (seg_hi !== 7'b1111111) begin
         errors++;
         $display("FAIL reset_release_cc: got %b expected %b", seg_hi, 7'b1111111);
      end
      checks++;
      if (seg_lo !== 7'b0000000) begin
         errors++;
         $display("FAIL reset_release_ca: got %b expected %b", seg_lo, 7'b0000000);
      end
   endtask

   task automatic test_sweep();
      for (int v = 0; v < 16; v++) begin
         binary_in = 4'(v);
         tick();
         checks++;
         if (seg_hi !== table_exp[v]) begin
            errors++;
            $display("FAIL sweep_cc %h: got %b expected %b", v, seg_hi, table_exp[v]);
         end
         checks++;
         if (seg_lo !== ~table_exp[v]) begin
            errors++;
            $display("FAIL sweep_ca %h: got %b expected %b", v, seg_lo, ~table_exp[v]);
         end
      end
   endtask

   task automatic test_blank();
      binary_in = 4'h3; blank = 1'b1;
      tick();
      checks++;
      if (seg_hi !== 7'b0000000) begin
         errors++;
         $display("FAIL blank_on_cc: got %b expected %b", seg_hi, 7'b0000000);
      end
      checks++;
      if (seg_lo !== 7'b1111111) begin
         errors++;
         $display("FAIL blank_on_ca: got %b expected %b", seg_lo, 7'b1111111);
      end
      blank = 1'b0;
      tick();
      checks++;
      if (seg_hi !== 7'b1111001) begin
         errors++;
         $display("FAIL blank_off_cc: got %b expected %b", seg_hi, 7'b1111001);
      end
   endtask

   task automatic test_polarity();
      binary_in = 4'h1;
      tick();
      checks++;
      if (seg_lo !== 7'b1001111) begin
         errors++;
         $display("FAIL polarity_one_ca: got %b expected %b", seg_lo, 7'b1001111);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (seg_lo !== 7'b1111111) begin
         errors++;
         $display("FAIL polarity_reset_ca: got %b expected %b", seg_lo, 7'b1111111);
      end
      // reset wins over blank too
      blank = 1'b1;
      tick();
      checks++;
      if (seg_hi !== 7'b0000000) begin
         errors++;
         $display("FAIL reset_over_blank_cc: got %b expected %b", seg_hi, 7'b0000000);
      end
      rst = 1'b0; blank = 1'b0;
      tick();
      checks++;
      if (seg_hi !== 7'b0110000) begin
         errors++;
         $display("FAIL post_reset_load_cc: got %b expected %b", seg_hi, 7'b0110000);
      end
   endtask

   task automatic test_hold();
      binary_in = 4'h2;
      tick();
      checks++;
      if (seg_hi !== 7'b1101101) begin
         errors++;
         $display("FAIL hold_load2_cc: got %b expected %b", seg_hi, 7'b1101101);
      end
      #2 binary_in = 4'h5;
      #1;
      checks++;
      if (seg_hi !== 7'b1101101) begin
         errors++;
         $display("FAIL hold_between_edges_cc: got %b expected %b", seg_hi, 7'b1101101);
      end
      tick();
      checks++;
      if (seg_hi !== 7'b1011011) begin
         errors++;
         $display("FAIL hold_load5_cc: got %b expected %b", seg_hi, 7'b1011011);
      end
      tick();
      checks++;
      if (seg_hi !== 7'b1011011) begin
         errors++;
         $display("FAIL hold_stable_cc: got %b expected %b", seg_hi, 7'b1011011);
      end
   endtask

   task automatic test_back_to_back();
      // alternate blank every cycle across changing codes
      binary_in = 4'hA; blank = 1'b0;
      tick();
      checks++;
      if (seg_hi !== 7'b1110111) begin
         errors++;
         $display("FAIL b2b_a_cc: got %b expected %b", seg_hi, 7'b1110111);
      end
      binary_in = 4'hB; blank = 1'b1;
      tick();
      checks++;
      if (seg_hi !== 7'b0000000) begin
         errors++;
         $display("FAIL b2b_blank_cc: got %b expected %b", seg_hi, 7'b0000000);
      end
      binary_in = 4'hD; blank = 1'b0;
      tick();
      checks++;
      if (seg_hi !== 7'b0111101) begin
         errors++;
         $display("FAIL b2b_d_cc: got %b expected %b", seg_hi, 7'b0111101);
      end
      checks++;
      if (seg_lo !== 7'b1000010) begin
         errors++;
         $display("FAIL b2b_d_ca: got %b expected %b", seg_lo, 7'b1000010);
      end
   endtask

`ifdef LAMP_TEST_EN
   task automatic test_lamp();
      lamp_test = 1'b1; blank = 1'b1; binary_in = 4'h0;
      tick();
      checks++;
      if (seg_hi !== 7'b1111111) begin
         errors++;
         $display("FAIL lamp_cc: got %b expected %b", seg_hi, 7'b1111111);
      end
      checks++;
      if (seg_lo !== 7'b0000000) begin
         errors++;
         $display("FAIL lamp_ca: got %b expected %b", seg_lo, 7'b0000000);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (seg_hi !== 7'b0000000) begin
         errors++;
         $display("FAIL lamp_rst_cc: got %b expected %b", seg_hi, 7'b0000000);
      end
      rst = 1'b0; lamp_test = 1'b0;
      tick();
      checks++;
      if (seg_hi !== 7'b0000000) begin
         errors++;
         $display("FAIL lamp_off_blank_cc: got %b expected %b", seg_hi, 7'b0000000);
      end
      blank = 1'b0;
      tick();
      checks++;
      if (seg_hi !== 7'b1111110) begin
         errors++;
         $display("FAIL lamp_off_decode_cc: got %b expected %b", seg_hi, 7'b1111110);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      table_exp[0]  = 7'b1111110; table_exp[1]  = 7'b0110000;
      table_exp[2]  = 7'b1101101; table_exp[3]  = 7'b1111001;
      table_exp[4]  = 7'b0110011; table_exp[5]  = 7'b1011011;
      table_exp[6]  = 7'b1011111; table_exp[7]  = 7'b1110000;
      table_exp[8]  = 7'b1111111; table_exp[9]  = 7'b1111011;
      table_exp[10] = 7'b1110111; table_exp[11] = 7'b0011111;
      table_exp[12] = 7'b1001110; table_exp[13] = 7'b0111101;
      table_exp[14] = 7'b1001111; table_exp[15] = 7'b1000111;
      rst = 1'b1; blank = 1'b0; lamp_test = 1'b0; binary_in = 4'h0;
      #2;
      test_reset();
      test_sweep();
      test_blank();
      test_polarity();
      test_hold();
      test_back_to_back();
`ifdef LAMP_TEST_EN
      test_lamp();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
Registered hex-to-seven-segment decoder. Converts a 4-bit binary nibble (0x0-0xF) into the seven segment-drive signals for one digit, with blanking and selectable output polarity. Sits between digit-multiplexing/display logic and the display pins. Output is registered so pin timing is clean.

Parameters:
ACTIVE_LOW, 0, 0 = segment lit when its bit is 1 (common cathode); 1 = all output bits inverted (common anode)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
binary_in  input  4  nibble to display, 0x0-0xF
blank  input  1  1 = all segments dark regardless of binary_in
segment_out  output  7  segment drive, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All behaviour in this section is stated for ACTIVE_LOW=0. For ACTIVE_LOW=1, segment_out is the bitwise inverse of every value listed here, including the reset value.
- Segment register updates on every rising clk edge. Latency is 1 cycle from binary_in/blank to segment_out. No handshake.
- Reset: when rst=1 at a rising edge, segment_out becomes 7'b0000000 (all segments dark).
- Priority per edge: rst, then blank, then decode.
- If blank=1, segment_out becomes all dark.
- Decode table, binary_in -> segment_out abcdefg:
  - 0 -> 1111110
  - 1 -> 0110000
  - 2 -> 1101101
  - 3 -> 1111001
  - 4 -> 0110011
  - 5 -> 1011011
  - 6 -> 1011111
  - 7 -> 1110000
  - 8 -> 1111111
  - 9 -> 1111011
  - A -> 1110111
  - b -> 0011111
  - C -> 1001110
  - d -> 0111101
  - E -> 1001111
  - F -> 1000111
- All 16 codes are defined; there is no default/illegal case. Any X/Z on binary_in may propagate; no masking is required.
- The output holds its last value while inputs are stable. Input changes take effect only at the next rising edge.
- If rst deasserts mid-stream, the first post-reset edge loads the decode of the current inputs.

Optional Feature:
LAMP_TEST_EN:
- When defined, adds input port lamp_test (1 bit).
- When lamp_test=1 at a rising edge and rst=0, segment_out becomes all segments lit (7'b1111111; inverted if ACTIVE_LOW=1). This overrides blank and decode.
- Priority becomes rst > lamp_test > blank > decode.
- When not defined, the port does not exist and behaviour is exactly as above.

Test Plan:
- Reset: rst=1 for 2 cycles with binary_in=8 -> segment_out=0000000. Release rst; the next edge gives 1111111.
- Full sweep: drive binary_in 0x0..0xF, one value per cycle -> each output matches the decode table one cycle later (e.g. 0->1111110, 7->1110000, A->1110111, F->1000111).
- Blank: binary_in=3, blank=1 -> 0000000. Drop blank -> next edge gives 1111001.
- Polarity: ACTIVE_LOW=1, binary_in=1 -> 1001111. Reset -> 1111111.
- Latency/hold: change binary_in from 2 to 5 between edges -> output stays 1101101 until the next edge, then becomes 1011011.
- With LAMP_TEST_EN: lamp_test=1, blank=1, binary_in=0 -> 1111111. Assert rst simultaneously -> 0000000.
